// File: rtl/hwpe_stream_buffer_pkg.sv
// Shared constants and width helpers for the hwpe_stream_buffer FIFO.
//   DefaultBufferWidth : default payload width in bits
//   DefaultDepth       : default number of entries
//   ptr_width()        : read/write pointer width for a given depth
//   cnt_width()        : occupancy counter width (must hold 0..depth)
//   is_pow2()          : power-of-two test used by the elaboration checks
package hwpe_stream_buffer_pkg;

  localparam int unsigned DefaultBufferWidth = 32;
  localparam int unsigned DefaultDepth       = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/hwpe_stream_buffer_ctrl.sv
// Pointer and occupancy control for hwpe_stream_buffer.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous flush, wins over push and pop
//   push_valid_i   : write-side valid
//   pop_ready_i    : read-side ready
//   push_ready_o   : count < DEPTH (state only)
//   pop_valid_o    : count != 0 (state only)
//   push_o         : a write into storage happens this cycle
//   wr_ptr_o       : slot written on push
//   rd_ptr_o       : slot presented on the read side
//   count_o        : current occupancy
module hwpe_stream_buffer_ctrl
  import hwpe_stream_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned PtrW = ptr_width(DEPTH),
  localparam int unsigned CntW = cnt_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_valid_i,
  input  logic            pop_ready_i,
  output logic            push_ready_o,
  output logic            pop_valid_o,
  output logic            push_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  // Handshake flags come from the counter alone, so no input reaches them.
  assign push_ready_o = (r_count < CntW'(DEPTH));
  assign pop_valid_o  = (r_count != '0);

  // A flush cancels both transfers in the same cycle.
  assign w_push = push_valid_i & push_ready_o & ~clear_i;
  assign w_pop  = pop_ready_i & pop_valid_o & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign push_o   = w_push;
  assign wr_ptr_o = r_wr_ptr;
  assign rd_ptr_o = r_rd_ptr;
  assign count_o  = r_count;

endmodule

// File: rtl/hwpe_stream_buffer.sv
// Small synchronous FIFO between a push stream and a pop stream.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (storage cleared too)
//   clear_i        : synchronous flush of pointers and count; storage kept
//   push_data_i    : write-side payload
//   push_valid_i   : write-side valid
//   push_ready_o   : write-side ready (buffer not full)
//   pop_data_o     : read-side payload, storage[rd_ptr]
//   pop_valid_o    : read-side valid (buffer not empty)
//   pop_ready_i    : read-side ready
//   count_o        : current occupancy, 0..DEPTH
module hwpe_stream_buffer
  import hwpe_stream_buffer_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH = DefaultBufferWidth,
  parameter int unsigned DEPTH        = DefaultDepth,
  localparam int unsigned PtrW        = ptr_width(DEPTH),
  localparam int unsigned CntW        = cnt_width(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [BUFFER_WIDTH-1:0] push_data_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  output logic [BUFFER_WIDTH-1:0] pop_data_o,
  output logic                    pop_valid_o,
  input  logic                    pop_ready_i,
  output logic [CntW-1:0]         count_o
);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_check
    $fatal(1, "hwpe_stream_buffer: DEPTH must be a power of two and >= 2");
  end

  logic [BUFFER_WIDTH-1:0] r_mem [DEPTH];
  logic                    w_push;
  logic [PtrW-1:0]         w_wr_ptr;
  logic [PtrW-1:0]         w_rd_ptr;

  hwpe_stream_buffer_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .push_valid_i (push_valid_i),
    .pop_ready_i  (pop_ready_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (pop_valid_o),
    .push_o       (w_push),
    .wr_ptr_o     (w_wr_ptr),
    .rd_ptr_o     (w_rd_ptr),
    .count_o      (count_o)
  );

  // Storage is zeroed on reset so the read side never shows X, but a flush
  // leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= push_data_i;
    end
  end

  assign pop_data_o = r_mem[w_rd_ptr];

endmodule

// File: tb/tb_hwpe_stream_buffer.sv
// Self-checking bench for hwpe_stream_buffer (BUFFER_WIDTH=32, DEPTH=4).
// Inputs change on the falling edge; outputs are sampled there too. A queue
// holds the expected FIFO contents and is updated at every rising edge.
module tb_hwpe_stream_buffer;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic [W-1:0]  push_data_i = '0;
  logic          push_valid_i = 1'b0;
  logic          push_ready_o;
  logic [W-1:0]  pop_data_o;
  logic          pop_valid_o;
  logic          pop_ready_i = 1'b0;
  logic [CW-1:0] count_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q [$];

  hwpe_stream_buffer #(
    .BUFFER_WIDTH (W),
    .DEPTH        (D)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .push_data_i  (push_data_i),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .pop_data_o   (pop_data_o),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic pv, input logic [W-1:0] pd, input logic pr, input logic clr);
    push_valid_i = pv;
    push_data_i  = pd;
    pop_ready_i  = pr;
    clear_i      = clr;
  endtask

  // Advance one clock; the model applies the FIFO rules at the rising edge.
  task automatic tick();
    bit do_push;
    bit do_pop;
    @(posedge clk_i);
    if (clear_i) begin
      exp_q.delete();
    end else begin
      do_pop  = pop_ready_i && (exp_q.size() != 0);
      do_push = push_valid_i && (exp_q.size() < D);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(push_data_i);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (push_ready_o !== 1'b1 || pop_valid_o !== 1'b0 || count_o !== '0 || pop_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_during: got rdy=%b vld=%b cnt=%0d data=%h want 1 0 0 0",
               push_ready_o, pop_valid_o, count_o, pop_data_o);
    end
    rst_ni = 1'b1;
    exp_q.delete();
    tick();
    n_cmp++;
    if (push_ready_o !== 1'b1 || pop_valid_o !== 1'b0 || count_o !== '0 || pop_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_after: got rdy=%b vld=%b cnt=%0d data=%h want 1 0 0 0",
               push_ready_o, pop_valid_o, count_o, pop_data_o);
    end
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_passthrough: got vld=%b want 0", pop_valid_o);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b1 || pop_data_o !== 32'hA5A5_0001 || count_o !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_push: got vld=%b data=%h cnt=%0d want 1 a5a50001 1",
               pop_valid_o, pop_data_o, count_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b0 || count_o !== '0) begin
      n_fail++;
      $display("FAIL single_drain: got vld=%b cnt=%0d want 0 0", pop_valid_o, count_o);
    end
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_overflow();
    fill_1_to_4();
    n_cmp++;
    if (count_o !== CW'(4) || push_ready_o !== 1'b0 || pop_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flags: got cnt=%0d rdy=%b vld=%b want 4 0 1",
               count_o, push_ready_o, pop_valid_o);
    end
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (count_o !== CW'(4)) begin
      n_fail++;
      $display("FAIL overflow_ignored: got cnt=%0d want 4", count_o);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (pop_valid_o !== 1'b1 || pop_data_o !== W'(i)) begin
        n_fail++;
        $display("FAIL overflow_drain%0d: got vld=%b data=%h want 1 %h", i, pop_valid_o, pop_data_o, W'(i));
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b0 || count_o !== '0) begin
      n_fail++;
      $display("FAIL overflow_empty: got vld=%b cnt=%0d want 0 0", pop_valid_o, count_o);
    end
  endtask

  task automatic test_full_push_pop();
    fill_1_to_4();
    drive(1'b1, 32'h5, 1'b1, 1'b0);
    n_cmp++;
    if (push_ready_o !== 1'b0 || pop_data_o !== 32'h1) begin
      n_fail++;
      $display("FAIL fullpp_pre: got rdy=%b data=%h want 0 1", push_ready_o, pop_data_o);
    end
    tick();
    n_cmp++;
    if (count_o !== CW'(3) || pop_data_o !== 32'h2) begin
      n_fail++;
      $display("FAIL fullpp_pop: got cnt=%0d data=%h want 3 2", count_o, pop_data_o);
    end
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (count_o !== CW'(4)) begin
      n_fail++;
      $display("FAIL fullpp_push: got cnt=%0d want 4", count_o);
    end
    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (pop_data_o !== W'(i)) begin
        n_fail++;
        $display("FAIL fullpp_drain%0d: got %h want %h", i, pop_data_o, W'(i));
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] base;
    base = $urandom;
    drive(1'b1, base, 1'b0, 1'b0);
    tick();
    drive(1'b1, base + 1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, base + W'(i + 2), 1'b1, 1'b0);
      n_cmp++;
      if (count_o !== CW'(2) || pop_data_o !== base + W'(i)) begin
        n_fail++;
        $display("FAIL stream%0d: got cnt=%0d data=%h want 2 %h", i, count_o, pop_data_o, base + W'(i));
      end
      tick();
    end
    for (int i = 10; i < 12; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (pop_data_o !== base + W'(i)) begin
        n_fail++;
        $display("FAIL stream_tail%0d: got %h want %h", i, pop_data_o, base + W'(i));
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    logic [W-1:0] val;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (count_o !== '0 || pop_valid_o !== 1'b0 || push_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: got cnt=%0d vld=%b rdy=%b want 0 0 1", count_o, pop_valid_o, push_ready_o);
    end
    val = $urandom;
    drive(1'b1, val, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (count_o !== CW'(1) || pop_data_o !== val) begin
      n_fail++;
      $display("FAIL clear_refill: got cnt=%0d data=%h want 1 %h", count_o, pop_data_o, val);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [W-1:0] val;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom | 32'h1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (count_o !== '0 || pop_valid_o !== 1'b0 || push_ready_o !== 1'b1 || pop_data_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d vld=%b rdy=%b data=%h want 0 0 1 0",
               count_o, pop_valid_o, push_ready_o, pop_data_o);
    end
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    val = $urandom;
    drive(1'b1, val, 1'b0, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_pre: got vld=%b want 0", pop_valid_o);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (pop_valid_o !== 1'b1 || pop_data_o !== val || count_o !== CW'(1)) begin
      n_fail++;
      $display("FAIL post_reset_push: got vld=%b data=%h cnt=%0d want 1 %h 1",
               pop_valid_o, pop_data_o, count_o, val);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(9, 0) < 7), $urandom, ($urandom_range(9, 0) < 6),
            ($urandom_range(31, 0) == 0));
      n_cmp++;
      if (push_ready_o !== (exp_q.size() < D) || pop_valid_o !== (exp_q.size() != 0) ||
          count_o !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random_flags@%0d: got rdy=%b vld=%b cnt=%0d want rdy=%b vld=%b cnt=%0d",
                 c, push_ready_o, pop_valid_o, count_o, (exp_q.size() < D),
                 (exp_q.size() != 0), exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (pop_data_o !== exp_q[0]) begin
          n_fail++;
          $display("FAIL random_data@%0d: got %h want %h", c, pop_data_o, exp_q[0]);
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
